// File: rtl/sdram_pattern_tester.sv
// Avalon-MM memory tester: writes pat(a) over [START_ADDR..END_ADDR], reads it back pipelined, counts mismatches.
// Define TESTER_INVERT_PASS_EN to run a second write/read pass with complemented data.
module sdram_pattern_tester #(
  parameter int                ADDR_W     = 22,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = 22'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 22'h3FFFFF,
  parameter logic [DATA_W-1:0] SEED       = 16'hA5C3,
  parameter int                MAX_OUTST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] az_addr,
  output logic [DATA_W-1:0] az_data,
  output logic [1:0]        az_be_n,
  output logic              az_wr_n,
  output logic              az_rd_n,
  input  logic              za_waitrequest,
  input  logic [DATA_W-1:0] za_data,
  input  logic              za_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        MAX_Q    = 4'(MAX_OUTST);

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
    pat = DATA_W'(a) ^ SEED ^ {DATA_W{inv}};
  endfunction

  state_e              state_q;
  logic [ADDR_W-1:0]   az_addr_q;
  logic [DATA_W-1:0]   az_data_q;
  logic                az_wr_n_q;
  logic                az_rd_n_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [15:0]         err_count_q;
  logic [ADDR_W-1:0]   first_err_addr_q;
  logic [ADDR_W-1:0]   ret_addr_q;
  logic [3:0]          outst_q;
  logic [3:0]          outst_d;
  logic                inv_q;
  logic                wr_acc_s;
  logic                rd_acc_s;
  logic                ret_s;
  logic                room_s;

  // Acceptance strobes, qualified read returns and next in-flight read count
  always_comb begin
    wr_acc_s = ~az_wr_n_q & ~za_waitrequest;
    rd_acc_s = ~az_rd_n_q & ~za_waitrequest;
    ret_s    = za_valid & ((state_q == S_READ) | (state_q == S_DRAIN)) & (outst_q != 4'd0);
    if (rd_acc_s & ~ret_s) begin
      outst_d = outst_q + 4'd1;
    end else if (~rd_acc_s & ret_s) begin
      outst_d = outst_q - 4'd1;
    end else begin
      outst_d = outst_q;
    end
    room_s = (outst_d < MAX_Q);
  end

  // Controller: command issue, in-flight tracking, return checking and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      az_addr_q        <= {ADDR_W{1'b0}};
      az_data_q        <= {DATA_W{1'b0}};
      az_wr_n_q        <= 1'b1;
      az_rd_n_q        <= 1'b1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= 16'h0000;
      first_err_addr_q <= {ADDR_W{1'b0}};
      ret_addr_q       <= {ADDR_W{1'b0}};
      outst_q          <= 4'd0;
      inv_q            <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (ret_s) begin
        if (ret_addr_q != END_ADDR) ret_addr_q <= ret_addr_q + ADDR_ONE;
        if (za_data != pat(ret_addr_q, inv_q)) begin
          if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
          if (err_count_q == 16'h0000) first_err_addr_q <= ret_addr_q;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q          <= S_WRITE;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= 16'h0000;
            first_err_addr_q <= {ADDR_W{1'b0}};
            inv_q            <= 1'b0;
            az_addr_q        <= START_ADDR;
            az_data_q        <= pat(START_ADDR, 1'b0);
            az_wr_n_q        <= 1'b0;
          end
        end
        S_WRITE: begin
          if (wr_acc_s) begin
            if (az_addr_q == END_ADDR) begin
              // Dropping the write strobe here gives the idle cycle before the first read
              az_wr_n_q  <= 1'b1;
              az_addr_q  <= START_ADDR;
              ret_addr_q <= START_ADDR;
              state_q    <= S_READ;
            end else begin
              az_addr_q <= az_addr_q + ADDR_ONE;
              az_data_q <= pat(az_addr_q + ADDR_ONE, inv_q);
            end
          end
        end
        S_READ: begin
          if (rd_acc_s) begin
            if (az_addr_q == END_ADDR) begin
              az_rd_n_q <= 1'b1;
              state_q   <= S_DRAIN;
            end else begin
              az_addr_q <= az_addr_q + ADDR_ONE;
              az_rd_n_q <= ~room_s;
            end
          end else if (az_rd_n_q) begin
            az_rd_n_q <= ~room_s;
          end
        end
        S_DRAIN: begin
          if (outst_q == 4'd0) begin
`ifdef TESTER_INVERT_PASS_EN
            if (!inv_q) begin
              inv_q     <= 1'b1;
              az_addr_q <= START_ADDR;
              az_data_q <= pat(START_ADDR, 1'b1);
              az_wr_n_q <= 1'b0;
              state_q   <= S_WRITE;
            end else begin
              state_q <= S_DONE;
            end
`else
            state_q <= S_DONE;
`endif
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_count_q == 16'h0000);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign az_addr        = az_addr_q;
  assign az_data        = az_data_q;
  assign az_be_n        = 2'b00;
  assign az_wr_n        = az_wr_n_q;
  assign az_rd_n        = az_rd_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester over an 8-word range: slave model with stalls/latency/faults and a command scoreboard.
module tb_sdram_pattern_tester;

  localparam int AW = 22;
  localparam int DW = 16;
`ifdef TESTER_INVERT_PASS_EN
  localparam int NPASS     = 2;
  localparam int ERR_CORR  = 2;
  localparam int ERR_STUCK = 8;
`else
  localparam int NPASS     = 1;
  localparam int ERR_CORR  = 1;
  localparam int ERR_STUCK = 4;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] az_addr;
  logic [DW-1:0] az_data;
  logic [1:0]    az_be_n;
  logic          az_wr_n;
  logic          az_rd_n;
  logic          za_waitrequest;
  logic [DW-1:0] za_data;
  logic          za_valid;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  sdram_pattern_tester #(
    .ADDR_W(AW), .DATA_W(DW), .START_ADDR(22'd0), .END_ADDR(22'd7),
    .SEED(16'hA5C3), .MAX_OUTST(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .az_addr(az_addr), .az_data(az_data), .az_be_n(az_be_n),
    .az_wr_n(az_wr_n), .az_rd_n(az_rd_n),
    .za_waitrequest(za_waitrequest), .za_data(za_data), .za_valid(za_valid),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic rd; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
  typedef struct packed { logic [31:0] due; logic [DW-1:0] data; } ret_t;
  typedef struct {
    string name; int lat; int stall_a; int stall_len; int corrupt; bit stuck; bit rnd;
    int exp_err; bit exp_pass; int exp_first; int exp_max;
  } rec_t;

  int n_pass = 0;
  int n_total = 0;

  cmd_t          exp_q[$];
  ret_t          rq[$];
  logic [DW-1:0] mem [0:7];
  int m_lat = 1, m_stall_a = -1, m_stall_len = 0, m_corrupt = -1;
  bit m_stuck = 0, m_rnd = 0;
  int stall_cnt, stall_acc, wr_cnt, outst_m, max_outst;
  bit stall_pend, stall_bad, both_low;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  logic [31:0]   cyc = 32'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [DW-1:0] pat_f(input int a, input int inv);
    logic [DW-1:0] p;
    p = 16'(a) ^ 16'hA5C3;
    pat_f = (inv != 0) ? ~p : p;
  endfunction

  // Slave model: decides waitrequest at the falling edge, records what the next rising edge accepts
  initial begin
    logic wreq;
    logic [DW-1:0] rdat;
    cmd_t e;
    ret_t r;
    za_waitrequest = 1'b0;
    za_valid = 1'b0;
    za_data = 16'h0000;
    forever begin
      @(negedge clk);
      cyc = cyc + 32'd1;
      wreq = 1'b0;
      if (stall_pend && (az_wr_n || az_addr != hold_a || az_data != hold_d)) stall_bad = 1'b1;
      if (!az_wr_n && int'(az_addr) == m_stall_a && stall_cnt < m_stall_len) begin
        if (stall_cnt == 0) begin
          hold_a = az_addr; hold_d = az_data; stall_pend = 1'b1;
        end
        wreq = 1'b1;
        stall_cnt++;
      end
      if (m_rnd && !wreq && $urandom_range(32'd3, 32'd0) == 32'd0) wreq = 1'b1;
      za_waitrequest = wreq;
      if (!az_wr_n && !az_rd_n) both_low = 1'b1;
      if (!wreq && (!az_wr_n || !az_rd_n)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 32'(az_addr), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("cmd_kind", 32'(!az_rd_n), 32'(e.rd));
          check("cmd_addr", 32'(az_addr), 32'(e.addr));
          if (!e.rd) check("wr_data", 32'(az_data), 32'(e.data));
        end
      end
      if (!az_wr_n && !wreq) begin
        mem[az_addr[2:0]] = az_data;
        wr_cnt++;
        stall_pend = 1'b0;
        if (int'(az_addr) == m_stall_a) stall_acc++;
      end
      if (!az_rd_n && !wreq) begin
        rdat = mem[az_addr[2:0]];
        if (int'(az_addr) == m_corrupt) rdat = 16'h0000;
        if (m_stuck) rdat[0] = 1'b0;
        r.due = cyc + 32'(m_lat);
        r.data = rdat;
        rq.push_back(r);
        outst_m++;
      end
      za_valid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        za_valid = 1'b1;
        za_data = r.data;
        outst_m--;
      end
      if (outst_m > max_outst) max_outst = outst_m;
    end
  end

  task automatic setup(input rec_t r);
    cmd_t c;
    m_lat = r.lat; m_stall_a = r.stall_a; m_stall_len = r.stall_len;
    m_corrupt = r.corrupt; m_stuck = r.stuck; m_rnd = r.rnd;
    stall_cnt = 0; stall_acc = 0; wr_cnt = 0; outst_m = 0; max_outst = 0;
    stall_pend = 1'b0; stall_bad = 1'b0; both_low = 1'b0;
    exp_q.delete();
    for (int p = 0; p < NPASS; p++) begin
      for (int a = 0; a < 8; a++) begin
        c.rd = 1'b0; c.addr = 22'(a); c.data = pat_f(a, p);
        exp_q.push_back(c);
      end
      for (int a = 0; a < 8; a++) begin
        c.rd = 1'b1; c.addr = 22'(a); c.data = 16'h0000;
        exp_q.push_back(c);
      end
    end
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_test(input rec_t r);
    int waited;
    @(negedge clk); #1;
    setup(r);
    repeat (3) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!done && waited < 3000) begin
      @(negedge clk); #1;
      waited++;
    end
    check({r.name, "_done"}, 32'(done), 32'd1);
    check({r.name, "_busy"}, 32'(busy), 32'd0);
    check({r.name, "_pass"}, 32'(pass), 32'(r.exp_pass));
    check({r.name, "_err_count"}, 32'(err_count), 32'(r.exp_err));
    check({r.name, "_first_err"}, 32'(first_err_addr), 32'(r.exp_first));
    check({r.name, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
    check({r.name, "_writes"}, 32'(wr_cnt), 32'(8 * NPASS));
    check({r.name, "_strobe_overlap"}, 32'(both_low), 32'd0);
    check({r.name, "_outst_le_max"}, 32'(max_outst <= 4), 32'd1);
    check({r.name, "_be_n"}, 32'(az_be_n), 32'd0);
    if (r.exp_max > 0) check({r.name, "_outst_peak"}, 32'(max_outst), 32'(r.exp_max));
    if (r.stall_a >= 0) begin
      check({r.name, "_stall_stable"}, 32'(stall_bad), 32'd0);
      check({r.name, "_stall_accepts"}, 32'(stall_acc), 32'(NPASS));
    end
    repeat (3) @(negedge clk);
    #1;
    check({r.name, "_done_hold"}, 32'(done), 32'd1);
    check({r.name, "_pass_hold"}, 32'(pass), 32'(r.exp_pass));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_n"}, 32'(az_wr_n), 32'd1);
    check({tag, "_rd_n"}, 32'(az_rd_n), 32'd1);
    check({tag, "_addr"}, 32'(az_addr), 32'd0);
    check({tag, "_data"}, 32'(az_data), 32'd0);
    check({tag, "_be_n"}, 32'(az_be_n), 32'd0);
    check({tag, "_status"}, {28'd0, busy, done, pass, 1'b0}, 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_first_err"}, 32'(first_err_addr), 32'd0);
  endtask

  rec_t tbl[6];

  initial begin
    int waited;
    tbl[0] = '{name:"T1_basic",   lat:1,  stall_a:-1, stall_len:0, corrupt:-1, stuck:0, rnd:0,
               exp_err:0,         exp_pass:1, exp_first:0, exp_max:0};
    tbl[1] = '{name:"T2_stall",   lat:1,  stall_a:3,  stall_len:5, corrupt:-1, stuck:0, rnd:0,
               exp_err:0,         exp_pass:1, exp_first:0, exp_max:0};
    tbl[2] = '{name:"T3_corrupt", lat:1,  stall_a:-1, stall_len:0, corrupt:5,  stuck:0, rnd:0,
               exp_err:ERR_CORR,  exp_pass:0, exp_first:5, exp_max:0};
    tbl[3] = '{name:"T4_latency", lat:10, stall_a:-1, stall_len:0, corrupt:-1, stuck:0, rnd:0,
               exp_err:0,         exp_pass:1, exp_first:0, exp_max:4};
    tbl[4] = '{name:"T6_stuck0",  lat:2,  stall_a:-1, stall_len:0, corrupt:-1, stuck:1, rnd:0,
               exp_err:ERR_STUCK, exp_pass:0, exp_first:0, exp_max:0};
    tbl[5] = '{name:"random_wait", lat:3, stall_a:-1, stall_len:0, corrupt:-1, stuck:0, rnd:1,
               exp_err:0,         exp_pass:1, exp_first:0, exp_max:0};

    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_test(tbl[i]);

    // Abort mid-read with two reads in flight, then confirm late returns are ignored
    @(negedge clk); #1;
    setup(tbl[3]);
    waited = 0;
    while (outst_m != 2 && waited < 500) begin
      @(negedge clk); #1;
      waited++;
    end
    check("T5_two_in_flight", 32'(outst_m), 32'd2);
    reset = 1'b1;
    #1;
    check_reset_outputs("T5_abort");
    @(negedge clk); #2;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check_reset_outputs("T5_late_valid");
    check("T5_returns_flushed", 32'(rq.size()), 32'd0);
    run_test(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
